// File: rtl/mac_activation_unit.sv
// mac_activation_unit
//   Computes LANES output neurons in parallel: each lane starts from its bias, accumulates
//   in_x * in_w_j over `length` input beats, applies an activation (none / ReLU / leaky ReLU)
//   and saturates the result to DW signed bits.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, length,      run request (IDLE only) with beat count, per-lane bias and activation
//   bias, act_mode      mode, all sampled on start
//   in_valid/in_ready,  input beat handshake; in_x is broadcast, in_w holds one weight per lane
//   in_x, in_w
//   out_valid/out_ready result handshake
//   out_data, sat       per-lane activated results; sat flags a clamp in any lane
//   busy                high whenever not idle
module mac_activation_unit #(
    parameter int unsigned LANES = 8,
    parameter int unsigned DW    = 8,
    parameter int unsigned KMAX  = 256,
    localparam int unsigned LW   = $clog2(KMAX + 1),
    localparam int unsigned ACCW = 2 * DW + $clog2(KMAX) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LW-1:0]         length,
    input  logic [LANES*DW-1:0]   bias,
    input  logic [1:0]            act_mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DW-1:0]         in_x,
    input  logic [LANES*DW-1:0]   in_w,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*DW-1:0]   out_data,
    output logic                  busy,
    output logic                  sat
);

    typedef enum logic [1:0] {StIdle, StAccum, StActivate, StOutput} state_e;

    localparam logic [LW-1:0]          KmaxLen = LW'(KMAX);
    localparam logic signed [ACCW-1:0] SatMax  = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SatMin  = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    state_e                  state_q, state_d;
    logic [LW-1:0]           cnt_q, cnt_d;
    logic [LW-1:0]           len_q, len_d;
    logic [1:0]              mode_q, mode_d;
    logic signed [ACCW-1:0]  acc_q [LANES];
    logic signed [ACCW-1:0]  acc_d [LANES];
    logic [LANES*DW-1:0]     out_q, out_d;
    logic                    sat_q, sat_d;

    logic signed [2*DW-1:0]  prod  [LANES];
    logic signed [ACCW-1:0]  act_v [LANES];
    logic [LANES*DW-1:0]     act_data;
    logic                    act_sat;
    logic                    beat;

    // Full-precision products; the accumulator width guarantees no overflow over KMAX beats.
    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            prod[j] = $signed(in_x) * $signed(in_w[j*DW +: DW]);
        end
    end

    // Activation and saturation of the finished accumulators.
    always_comb begin
        act_data = '0;
        act_sat  = 1'b0;
        for (int j = 0; j < LANES; j++) begin
            act_v[j] = acc_q[j];
            case (mode_q)
                2'b01:   if (acc_q[j] < 0) act_v[j] = '0;
                2'b10:   if (acc_q[j] < 0) act_v[j] = acc_q[j] >>> 3;
                default: act_v[j] = acc_q[j];
            endcase
            if (act_v[j] > SatMax) begin
                act_data[j*DW +: DW] = SatMax[DW-1:0];
                act_sat              = 1'b1;
            end else if (act_v[j] < SatMin) begin
                act_data[j*DW +: DW] = SatMin[DW-1:0];
                act_sat              = 1'b1;
            end else begin
                act_data[j*DW +: DW] = act_v[j][DW-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        mode_d   = mode_q;
        acc_d    = acc_q;
        out_d    = out_q;
        sat_d    = sat_q;
        in_ready = (state_q == StAccum) && (cnt_q < len_q);
        beat     = in_valid && in_ready;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StAccum;
                    cnt_d   = '0;
                    len_d   = (length > KmaxLen) ? KmaxLen : length;
                    mode_d  = act_mode;
                    for (int j = 0; j < LANES; j++) begin
                        acc_d[j] = ACCW'($signed(bias[j*DW +: DW]));
                    end
                end
            end
            StAccum: begin
                if (beat) begin
                    cnt_d = cnt_q + LW'(1);
                    for (int j = 0; j < LANES; j++) begin
                        acc_d[j] = acc_q[j] + ACCW'(prod[j]);
                    end
                    // Leave on the last beat itself so out_valid follows two cycles later.
                    if (cnt_q + LW'(1) == len_q) state_d = StActivate;
                end else if (cnt_q == len_q) begin
                    // Only reachable for a zero-length run.
                    state_d = StActivate;
                end
            end
            StActivate: begin
                out_d   = act_data;
                sat_d   = act_sat;
                state_d = StOutput;
            end
            StOutput: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            len_q   <= '0;
            mode_q  <= '0;
            acc_q   <= '{default: '0};
            out_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            sat_q   <= sat_d;
        end
    end

    assign out_valid = (state_q == StOutput);
    assign busy      = (state_q != StIdle);
    assign out_data  = out_q;
    assign sat       = sat_q && out_valid;

endmodule

// File: tb/tb_mac_activation_unit.sv
module tb_mac_activation_unit;

    localparam int unsigned LANES = 8;
    localparam int unsigned DW    = 8;
    localparam int unsigned KMAX  = 256;
    localparam int unsigned LW    = $clog2(KMAX + 1);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [LW-1:0]        length;
    logic [LANES*DW-1:0]  bias;
    logic [1:0]           act_mode;
    logic                 in_valid;
    logic                 in_ready;
    logic [DW-1:0]        in_x;
    logic [LANES*DW-1:0]  in_w;
    logic                 out_valid;
    logic                 out_ready;
    logic [LANES*DW-1:0]  out_data;
    logic                 busy;
    logic                 sat;

    int checks   = 0;
    int failures = 0;

    mac_activation_unit #(
        .LANES (LANES),
        .DW    (DW),
        .KMAX  (KMAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .length    (length),
        .bias      (bias),
        .act_mode  (act_mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_w      (in_w),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .sat       (sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Pulse start, then scramble the sampled inputs to prove they were captured.
    task automatic do_start(input logic [LW-1:0] len, input logic [63:0] b, input logic [1:0] m);
        @(negedge clk);
        start    = 1'b1;
        length   = len;
        bias     = b;
        act_mode = m;
        @(negedge clk);
        start    = 1'b0;
        length   = 9'd3;
        bias     = ~b;
        act_mode = ~m;
    endtask

    // Offer beats until out_valid; count accepted beats and cycles from last beat to out_valid.
    task automatic run(input string tag, input logic [LW-1:0] len, input logic [63:0] b,
                       input logic [1:0] m, input logic [7:0] x, input logic [63:0] w,
                       input bit gaps, output logic [63:0] data, output logic s,
                       output int beats, output int lat);
        bit tog = 1'b0;
        bit timeout = 1'b1;
        do_start(len, b, m);
        beats = 0;
        lat   = 0;
        for (int c = 0; c < 2000; c++) begin
            lat++;
            if (out_valid) begin
                timeout = 1'b0;
                break;
            end
            in_valid = gaps ? tog : 1'b1;
            tog      = ~tog;
            in_x     = x;
            in_w     = w;
            if (in_valid && in_ready) begin
                beats++;
                lat = 0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check({tag, "_timeout"}, 64'(timeout), 64'd0);
        data = out_data;
        s    = sat;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    logic [63:0] d;
    logic        s;
    int          nb;
    int          lat;
    bit          seen;

    initial begin
        rst = 1'b1; start = 1'b0; length = '0; bias = '0; act_mode = '0;
        in_valid = 1'b0; in_x = '0; in_w = '0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_sat", 64'(sat), 64'd0);
        rst = 1'b0;

        // Basic run: 1 + 8*1*1 = 9 per lane.
        run("t1", 9'd8, {8{8'h01}}, 2'b00, 8'h01, {8{8'h01}}, 1'b0, d, s, nb, lat);
        check("t1_data", d, 64'h0909_0909_0909_0909);
        check("t1_sat", 64'(s), 64'd0);
        check("t1_beats", 64'(nb), 64'd8);
        check("t1_latency", 64'(lat), 64'd2);
        check("t1_busy", 64'(busy), 64'd1);
        handshake();
        check("t1_busy_after", 64'(busy), 64'd0);
        check("t1_valid_after", 64'(out_valid), 64'd0);

        // ReLU: -16 + 8 = -8 -> 0.
        run("t2", 9'd8, {8{8'hF0}}, 2'b01, 8'h01, {8{8'h01}}, 1'b0, d, s, nb, lat);
        check("t2_relu", d, 64'h0);
        check("t2_sat", 64'(s), 64'd0);
        handshake();

        // Leaky, zero length: -72 >>> 3 = -9.
        run("t3", 9'd0, {8{8'hB8}}, 2'b10, 8'h01, {8{8'h01}}, 1'b0, d, s, nb, lat);
        check("t3_leaky", d, 64'hF7F7_F7F7_F7F7_F7F7);
        check("t3_beats", 64'(nb), 64'd0);
        handshake();

        // Mode 11 behaves as pass-through.
        run("t4", 9'd0, {8{8'hF0}}, 2'b11, 8'h01, {8{8'h01}}, 1'b0, d, s, nb, lat);
        check("t4_mode3", d, 64'hF0F0_F0F0_F0F0_F0F0);
        handshake();

        // Leaky with positive accumulator is unchanged: 0x10 + 4*3 = 0x1C.
        run("t5", 9'd4, {8{8'h10}}, 2'b10, 8'h03, {8{8'h01}}, 1'b0, d, s, nb, lat);
        check("t5_leaky_pos", d, 64'h1C1C_1C1C_1C1C_1C1C);
        handshake();

        // Positive and negative saturation.
        run("t6", 9'd8, 64'h0, 2'b00, 8'h7F, {8{8'h7F}}, 1'b0, d, s, nb, lat);
        check("t6_sat_pos", d, 64'h7F7F_7F7F_7F7F_7F7F);
        check("t6_sat_flag", 64'(s), 64'd1);
        handshake();
        check("t6_sat_cleared", 64'(sat), 64'd0);
        run("t7", 9'd8, 64'h0, 2'b00, 8'h7F, {8{8'h80}}, 1'b0, d, s, nb, lat);
        check("t7_sat_neg", d, 64'h8080_8080_8080_8080);
        check("t7_sat_flag", 64'(s), 64'd1);
        handshake();

        // Gapped vs gap-free: lane j = 4 * 2 * j.
        run("t8", 9'd4, 64'h0, 2'b00, 8'h02, 64'h0706_0504_0302_0100, 1'b1, d, s, nb, lat);
        check("t8_gaps", d, 64'h3830_2820_1810_0800);
        check("t8_beats", 64'(nb), 64'd4);
        handshake();
        run("t9", 9'd4, 64'h0, 2'b00, 8'h02, 64'h0706_0504_0302_0100, 1'b0, d, s, nb, lat);
        check("t9_nogaps", d, 64'h3830_2820_1810_0800);
        handshake();

        // Length beyond KMAX is clamped.
        run("t10", 9'd300, {8{8'h05}}, 2'b00, 8'h00, 64'h0, 1'b0, d, s, nb, lat);
        check("t10_clamp_beats", 64'(nb), 64'd256);
        check("t10_data", d, 64'h0505_0505_0505_0505);
        handshake();

        // Backpressure with an ignored start pulse.
        run("t11", 9'd8, {8{8'h01}}, 2'b00, 8'h01, {8{8'h01}}, 1'b0, d, s, nb, lat);
        for (int c = 0; c < 5; c++) begin
            start  = (c == 2);
            length = 9'd0;
            @(negedge clk);
            check("t11_hold_valid", 64'(out_valid), 64'd1);
            check("t11_hold_data", out_data, 64'h0909_0909_0909_0909);
        end
        start = 1'b0;
        handshake();
        check("t11_busy_drop", 64'(busy), 64'd0);
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid || busy) seen = 1'b1;
        end
        check("t11_no_second", 64'(seen), 64'd0);

        // Reset after 3 of 8 beats discards the run.
        do_start(9'd8, {8{8'h01}}, 2'b00);
        in_x = 8'h01; in_w = {8{8'h01}}; in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t12_busy", 64'(busy), 64'd0);
        check("t12_in_ready", 64'(in_ready), 64'd0);
        check("t12_out_data", out_data, 64'h0);
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("t12_no_valid", 64'(seen), 64'd0);
        run("t13", 9'd8, {8{8'h01}}, 2'b00, 8'h01, {8{8'h01}}, 1'b0, d, s, nb, lat);
        check("t13_after_rst", d, 64'h0909_0909_0909_0909);
        handshake();

        // Reset dominates start on the same edge.
        rst = 1'b1; start = 1'b1; length = 9'd2;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("t14_rst_vs_start", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
